// File: rtl/main_mem_burst_if.sv
// Request/beat bundle between the cache controller (master) and the burst memory (slave).
// Latency: none, plain wires.
// Backpressure: req_rdy gates request acceptance; beats themselves are never backpressured.
interface main_mem_burst_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_vld;
  logic                  rd_last;
  logic                  wr_done;

  modport master (
    output flush, req_vld, req_we, req_addr, wr_data, wr_vld,
    input  req_rdy, rd_data, rd_vld, rd_last, wr_done
  );

  modport slave (
    input  flush, req_vld, req_we, req_addr, wr_data, wr_vld,
    output req_rdy, rd_data, rd_vld, rd_last, wr_done
  );
endinterface

// File: rtl/main_mem_burst.sv
// Main-memory model serving cache-line bursts, critical word first, wrapping within the line.
// Latency: first read beat RD_LATENCY cycles after acceptance; write beats start the next cycle.
// Backpressure: req_rdy only in IDLE without flush; read beats cannot stall, write beats stall on wr_vld=0.
module main_mem_burst #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int RD_LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  main_mem_burst_if.slave bus
);
  localparam int OFF    = $clog2(DATA_WIDTH / 8);
  localparam int LOFF   = $clog2(LINE_WORDS);
  localparam int IW     = ADDR_WIDTH - OFF;
  localparam int LINE_W = IW - LOFF;
  localparam int DEPTH  = 1 << IW;
  localparam int LAT_W  = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, LAT, RD, WR} state_e;

  state_e                state_q, state_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [LOFF-1:0]       off_q, off_d;
  logic [LOFF-1:0]       beat_q, beat_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_last_q, rd_last_d;
  logic                  wr_done_q, wr_done_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  req_rdy;
  logic                  accept;
  logic                  mem_we;
  logic [IW-1:0]         beat_idx;

  // Byte-lane bits of the address carry no information for word-granular bursts.
  generate
    if (OFF > 0) begin : g_lsb
      logic unused_lsbs;
      assign unused_lsbs = ^bus.req_addr[OFF-1:0];
    end
  endgenerate

  assign req_rdy  = (state_q == IDLE) && !bus.flush;
  assign accept   = bus.req_vld && req_rdy;
  // Offset add is LOFF bits wide, so the beat address wraps inside the line.
  assign beat_idx = {line_q, off_q + beat_q};

  // State and datapath registers; memory contents are deliberately outside this reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      line_q    <= '0;
      off_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      off_q     <= off_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Next-state: RD lingers one extra cycle while rd_last is shown, so req_rdy returns after it.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = bus.req_we ? WR : ((RD_LATENCY == 1) ? RD : LAT);
        LAT:  if (lat_q == LAT_W'(RD_LATENCY - 1)) state_d = RD;
        RD:   if (rd_last_q) state_d = IDLE;
        WR:   if (bus.wr_vld && (&beat_q)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath controls: latch request, count latency/beats, issue read beats, enable writes.
  always_comb begin
    line_d    = line_q;
    off_d     = off_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    rd_last_d = 1'b0;
    wr_done_d = 1'b0;
    mem_we    = 1'b0;
    if (bus.flush) begin
      beat_d = '0;
      lat_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            line_d = bus.req_addr[ADDR_WIDTH-1:OFF+LOFF];
            off_d  = bus.req_addr[OFF+LOFF-1:OFF];
            beat_d = '0;
            lat_d  = LAT_W'(1);
          end
        end
        LAT: begin
          if (lat_q == LAT_W'(RD_LATENCY - 1)) lat_d = '0;
          else                                 lat_d = lat_q + 1'b1;
        end
        RD: begin
          if (!rd_last_q) begin
            rd_data_d = mem_q[beat_idx];
            rd_vld_d  = 1'b1;
            rd_last_d = &beat_q;
            beat_d    = beat_q + 1'b1;
          end
        end
        WR: begin
          if (bus.wr_vld) begin
            mem_we    = 1'b1;
            wr_done_d = &beat_q;
            beat_d    = beat_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage: flush zeroes every word, otherwise one write beat per cycle.
  always_ff @(posedge clk) begin
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[beat_idx] <= bus.wr_data;
    end
  end

  assign bus.req_rdy = req_rdy;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.rd_last = rd_last_q;
  assign bus.wr_done = wr_done_q;
endmodule

// File: tb/tb_main_mem_burst.sv
// Directed bench for main_mem_burst: bursts, wrap order, stalls, flush, reset mid-write.
// Latency: checks first read beat exactly two cycles after acceptance.
// Backpressure: exercises wr_vld stalls and held req_vld back-to-back acceptance.
module tb_main_mem_burst;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  main_mem_burst_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus();

  main_mem_burst #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .LINE_WORDS(4),
    .RD_LATENCY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read one line and check latency, beat order, rd_last placement and ready return.
  task automatic read_line(input string tag, input logic [15:0] addr,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    int lat;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    bus.req_we   = 1'b0;
    bus.req_addr = addr;
    bus.req_vld  = 1'b1;
    chk({tag, "/rdy"}, bus.req_rdy, 1);
    tick();
    bus.req_vld = 1'b0;
    chk({tag, "/done_clr"}, bus.wr_done, 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.rd_vld && lat < 20);
    chk({tag, "/lat"}, lat, 2);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      chk({tag, $sformatf("/vld%0d", b)}, bus.rd_vld, 1);
      chk({tag, $sformatf("/dat%0d", b)}, bus.rd_data, e[b]);
      chk({tag, $sformatf("/last%0d", b)}, bus.rd_last, (b == 3));
    end
    chk({tag, "/rdy_in_last"}, bus.req_rdy, 0);
    tick();
    chk({tag, "/vld_end"}, bus.rd_vld, 0);
    chk({tag, "/rdy_end"}, bus.req_rdy, 1);
  endtask

  // Write one line; pat bit k (LSB first) is wr_vld in the k-th cycle after acceptance.
  task automatic write_line(input string tag, input logic [15:0] addr,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic [7:0] pat);
    logic [31:0] d [4];
    int beats;
    int cyc;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    bus.req_we   = 1'b1;
    bus.req_addr = addr;
    bus.req_vld  = 1'b1;
    chk({tag, "/rdy"}, bus.req_rdy, 1);
    tick();
    bus.req_vld = 1'b0;
    bus.req_we  = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 16) begin
      chk({tag, "/done_early"}, bus.wr_done, 0);
      bus.wr_vld  = pat[cyc % 8];
      bus.wr_data = bus.wr_vld ? d[beats] : 32'hDEAD_BEEF;
      tick();
      if (bus.wr_vld) beats++;
      cyc++;
    end
    bus.wr_vld  = 1'b0;
    bus.wr_data = 32'h0;
    chk({tag, "/done"}, bus.wr_done, 1);
    chk({tag, "/rdy_after"}, bus.req_rdy, 1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.req_vld  = 1'b0;
    bus.req_we   = 1'b0;
    bus.req_addr = 16'h0;
    bus.wr_data  = 32'h0;
    bus.wr_vld   = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst/rd_vld",  bus.rd_vld,  0);
    chk("rst/rd_last", bus.rd_last, 0);
    chk("rst/wr_done", bus.wr_done, 0);
    chk("rst/rd_data", bus.rd_data, 0);
    #2 rst = 1'b0;
    tick();
    chk("rst/req_rdy", bus.req_rdy, 1);

    // Preload word[i] = i; last line written critical-word-first from word 13
    write_line("pre0", 16'h0000, 32'd0,  32'd1,  32'd2,  32'd3,  8'hFF);
    write_line("pre1", 16'h0010, 32'd4,  32'd5,  32'd6,  32'd7,  8'hFF);
    write_line("pre2", 16'h0020, 32'd8,  32'd9,  32'd10, 32'd11, 8'hFF);
    write_line("pre3", 16'h0034, 32'd13, 32'd14, 32'd15, 32'd12, 8'hFF);

    // Plain and critical-word-first reads
    read_line("rd10", 16'h0010, 32'd4, 32'd5, 32'd6, 32'd7);
    read_line("rd18", 16'h0018, 32'd6, 32'd7, 32'd4, 32'd5);

    // Write with stalls 1,0,1,1,0,1 then read accepted in the wr_done cycle
    write_line("wr20", 16'h0020, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 8'b0010_1101);
    read_line("raw20", 16'h0020, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Back-to-back reads with req_vld held: second accepted the cycle after rd_last
    bus.req_we   = 1'b0;
    bus.req_addr = 16'h0000;
    bus.req_vld  = 1'b1;
    tick();
    bus.req_addr = 16'h0034;
    for (int c = 1; c <= 13; c++) begin
      logic ev;
      tick();
      ev = ((c >= 2) && (c <= 5)) || ((c >= 9) && (c <= 12));
      chk($sformatf("b2b/vld_c%0d", c), bus.rd_vld, ev);
      chk($sformatf("b2b/last_c%0d", c), bus.rd_last, (c == 5) || (c == 12));
      if (c >= 2 && c <= 5) chk($sformatf("b2b/dat_c%0d", c), bus.rd_data, c - 2);
      if (c >= 9 && c <= 12) chk($sformatf("b2b/dat_c%0d", c), bus.rd_data, 12 + ((c - 8) % 4));
      if (c == 5)  chk("b2b/rdy_last",  bus.req_rdy, 0);
      if (c == 6)  chk("b2b/rdy_after", bus.req_rdy, 1);
      if (c == 13) chk("b2b/rdy_end",   bus.req_rdy, 1);
      if (c == 7)  bus.req_vld = 1'b0;
    end

    // Reset mid-write after two beats of line 0x30
    bus.req_we   = 1'b1;
    bus.req_addr = 16'h0030;
    bus.req_vld  = 1'b1;
    chk("rstw/rdy", bus.req_rdy, 1);
    tick();
    bus.req_vld = 1'b0;
    bus.req_we  = 1'b0;
    bus.wr_vld  = 1'b1;
    bus.wr_data = 32'hB0;
    tick();
    bus.wr_data = 32'hB1;
    tick();
    bus.wr_data = 32'hBAD2;
    #2 rst = 1'b1;
    #1;
    chk("rstw/rd_vld",  bus.rd_vld,  0);
    chk("rstw/rd_last", bus.rd_last, 0);
    chk("rstw/wr_done", bus.wr_done, 0);
    chk("rstw/rd_data", bus.rd_data, 0);
    bus.wr_vld = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rstw/req_rdy", bus.req_rdy, 1);
    read_line("rd30", 16'h0030, 32'hB0, 32'hB1, 32'd14, 32'd15);

    // Flush during read beat 2, flush blocks a same-cycle request
    bus.req_we   = 1'b0;
    bus.req_addr = 16'h0010;
    bus.req_vld  = 1'b1;
    tick();
    bus.req_vld = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("fl/beat2_vld", bus.rd_vld, 1);
    chk("fl/beat2_dat", bus.rd_data, 32'd6);
    bus.flush = 1'b1;
    tick();
    chk("fl/vld_off",  bus.rd_vld,  0);
    chk("fl/last_off", bus.rd_last, 0);
    bus.req_vld = 1'b1;
    chk("fl/rdy_blocked", bus.req_rdy, 0);
    tick();
    bus.flush   = 1'b0;
    bus.req_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fl/quiet%0d", k), {bus.rd_vld, bus.rd_last, bus.wr_done}, 3'b000);
      tick();
    end
    read_line("flz10", 16'h0010, 32'd0, 32'd0, 32'd0, 32'd0);
    read_line("flz34", 16'h0034, 32'd0, 32'd0, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/main_mem_burst.md
Name: main_mem_burst

Overview:
- Parametrised successor to the single-word backing memory for the direct-mapped cache.
- Serves whole cache-line refills and writebacks as bursts of LINE_WORDS words, with a programmable read latency and valid/ready request handshake.
- Uses separate read/write data buses (no tristate).
- Delivers the critical word first, wrapping within the line.
- Sits between the cache controller and the testbench/top-level as the main-memory model.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 32, word width in bits; multiple of 8, power of two.
- LINE_WORDS, 4, words per burst/cache line; power of two, ≥2.
- RD_LATENCY, 2, cycles from request acceptance to first read beat; ≥1.
- Derived: OFF = log2(DATA_WIDTH/8); LOFF = log2(LINE_WORDS); DEPTH = 2^(ADDR_WIDTH-OFF) words.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of memory contents and abort of any burst.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_we  in  1  1 = line write, 0 = line read; sampled on acceptance.
- req_addr  in  ADDR_WIDTH  byte address of critical word; low OFF bits ignored.
- wr_data  in  DATA_WIDTH  write beat data.
- wr_vld  in  1  write beat valid.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_vld  out  1  read beat valid.
- rd_last  out  1  final read beat of burst.
- wr_done  out  1  one-cycle pulse after final write beat is stored.

Behaviour:
- Reset: asynchronous, active-high.
  - State = IDLE; req_rdy=1 after release; rd_vld=0, rd_last=0, wr_done=0, rd_data=0; latency counter and beat counter = 0.
  - Memory array is not reset.
- Word index = req_addr[ADDR_WIDTH-1:OFF]; line base = index with low LOFF bits cleared; start offset = index[LOFF-1:0].
- Beat n (0..LINE_WORDS-1) targets base + ((offset + n) mod LINE_WORDS), wrapping within the line, never crossing into the next line.
- Handshake:
  - req_rdy = (state==IDLE) && !flush, combinational.
  - Request accepted on the edge where req_vld && req_rdy; address, offset and req_we are latched then.
- FSM states: IDLE, LAT, RD, WR.
  - IDLE → LAT on accepted read; IDLE → WR on accepted write.
  - LAT: counts RD_LATENCY-1 cycles (skipped if RD_LATENCY==1), then → RD.
  - RD: outputs one beat per cycle for LINE_WORDS consecutive cycles, no gaps.
    - First rd_vld is high exactly RD_LATENCY cycles after the acceptance edge.
    - rd_data is registered from memory.
    - rd_last is high with beat LINE_WORDS-1.
    - → IDLE after last beat; req_rdy is high the cycle after rd_last.
  - WR: beats start the cycle after acceptance.
    - Each cycle with wr_vld=1 writes wr_data to the current wrapped word and advances the beat count.
    - wr_vld=0 stalls without side effect.
    - After beat LINE_WORDS-1 is written → IDLE; wr_done=1 for exactly the next cycle, concurrent with req_rdy=1.
  - wr_vld outside WR is ignored.
- Flush (synchronous, any state):
  - All DEPTH words become 0; FSM → IDLE; counters clear; rd_vld, rd_last, wr_done deassert next cycle.
  - In-flight bursts are aborted with no rd_last or wr_done.
  - Flush dominates a same-cycle request (req_rdy is low).
- rst asserted mid-burst: immediate return to reset values; partially written words remain as written.
- Read-after-write: a read accepted in the wr_done cycle returns the newly written data.

Test Plan:
- Reset then read line at addr 0x0010, RD_LATENCY=2, memory preloaded word[i]=i → rd_vld 2 cycles after acceptance; words 4,5,6,7; rd_last on 4th beat; req_rdy back next cycle.
- Critical-word-first: read at addr 0x0018 (word 6) → beats 6,7,4,5; rd_last with word 5.
- Write burst at 0x0020 with wr_vld pattern 1,0,1,1,0,1 and data A0..A3 → words 8..11 = A0..A3; wr_done one cycle after 4th beat; readback matches.
- Flush asserted during RD beat 2 → rd_vld low next cycle, no rd_last; any subsequent read returns 0s.
- Back-to-back: request held asserted → next request accepted the cycle after rd_last/wr_done; no beat overlap or gap within a burst.
- rst pulsed mid-WR after 2 beats → outputs at reset values immediately; words 0,1 of the line updated, words 2,3 unchanged.
